// File: rtl/timer_responder.sv
// Memory-mapped programmable countdown timer on the processor bridge bus.
// Word offsets: 0=CTRL {IM, MODE[1:0], EN}, 1=PRESET, 2=COUNT (read-only), 3=reserved.
// Raises irq either as a sticky level (one-shot) or as a one-cycle pulse per period
// (auto-reload).
module timer_responder #(
    parameter int unsigned CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        irq
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StCnt,
        StInt
    } state_e;

    state_e             state_q, state_d;
    logic               en_q, en_d;
    logic [1:0]         mode_q, mode_d;
    logic               im_q, im_d;
    logic               sticky_q, sticky_d;
    logic [CNT_W-1:0]   preset_q, preset_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               ctrl_wr;
    logic               preset_wr;
    logic               auto_reload;

    assign ctrl_wr     = sel & we & (addr == 2'd0);
    assign preset_wr   = sel & we & (addr == 2'd1);
    // Modes 2 and 3 fall back to one-shot behaviour.
    assign auto_reload = (mode_q == 2'd1);

    // State and register file update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            en_q     <= 1'b0;
            mode_q   <= 2'd0;
            im_q     <= 1'b0;
            sticky_q <= 1'b0;
            preset_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            mode_q   <= mode_d;
            im_q     <= im_d;
            sticky_q <= sticky_d;
            preset_q <= preset_d;
            count_q  <= count_d;
        end
    end

    // Next-state logic: FSM first, then software writes override its side effects.
    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        mode_d   = mode_q;
        im_d     = im_q;
        sticky_d = sticky_q;
        preset_d = preset_q;
        count_d  = count_q;

        case (state_q)
            StIdle: begin
                if (en_q) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                count_d = preset_q;
                state_d = StCnt;
            end
            StCnt: begin
                if (!en_q) begin
                    // Disabled mid-count: freeze COUNT; re-enabling restarts via LOAD.
                    state_d = StIdle;
                end else if (count_q == '0) begin
                    state_d = StInt;
                    if (!auto_reload) begin
                        sticky_d = 1'b1;
                    end
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            StInt: begin
                if (auto_reload) begin
                    state_d = StLoad;
                end else begin
                    en_d    = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A CTRL write wins over the FSM clearing EN or setting the sticky flag.
        if (ctrl_wr) begin
            en_d     = wd[0];
            mode_d   = wd[2:1];
            im_d     = wd[3];
            sticky_d = 1'b0;
        end
        if (preset_wr) begin
            preset_d = wd[CNT_W-1:0];
        end
    end

    // Combinational read mux, zero when the device is not selected.
    always_comb begin
        rd = '0;
        if (sel) begin
            case (addr)
                2'd0:    rd = {28'd0, im_q, mode_q, en_q};
                2'd1:    rd = 32'(preset_q);
                2'd2:    rd = 32'(count_q);
                default: rd = '0;
            endcase
        end
    end

    // Built only from registered terms so the interrupt line cannot glitch.
    assign irq = im_q & (sticky_q | ((state_q == StInt) & auto_reload));

endmodule

// File: tb/tb_timer_responder.sv
// Scoreboard bench for timer_responder: each read probe pushes its expected
// {rd, irq}; a monitor pops and compares on the falling edge of every read cycle.
module tb_timer_responder;

    logic        clk;
    logic        reset;
    logic        sel;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        irq;

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic        irq;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   n_pass  = 0;
    int   n_total = 0;

    timer_responder #(.CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .sel   (sel),
        .addr  (addr),
        .we    (we),
        .wd    (wd),
        .rd    (rd),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle bus write; the sampling edge is the next rising edge.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        sel  = 1'b1;
        we   = 1'b1;
        addr = a;
        wd   = d;
        @(posedge clk);
        #1;
        sel = 1'b0;
        we  = 1'b0;
        wd  = '0;
    endtask

    // One-cycle read; sees state left by the previous rising edge.
    task automatic probe(input string nm, input logic [1:0] a, input logic [31:0] erd,
                         input logic eirq);
        exp_t e;
        e.name = nm;
        e.rd   = erd;
        e.irq  = eirq;
        exp_q.push_back(e);
        sel  = 1'b1;
        we   = 1'b0;
        addr = a;
        @(posedge clk);
        #1;
        sel = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every read cycle against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (sel && !we) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_read: rd=%h irq=%b, no expectation queued", rd, irq);
                end else begin
                    cur = exp_q.pop_front();
                    if (rd === cur.rd && irq === cur.irq) begin
                        n_pass++;
                    end else begin
                        $display("FAIL %s: got rd=%h irq=%b, expected rd=%h irq=%b",
                                 cur.name, rd, irq, cur.rd, cur.irq);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        sel   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wd    = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        tick();

        // Reset values, COUNT and offset 3 ignore writes.
        for (int a = 0; a < 4; a++) begin
            probe($sformatf("reset_off%0d", a), 2'(a), 32'h0, 1'b0);
        end
        bus_write(2'd2, 32'h55);
        probe("count_ro", 2'd2, 32'h0, 1'b0);
        bus_write(2'd3, 32'hdead_beef);
        probe("off3_ro", 2'd3, 32'h0, 1'b0);

        // One-shot, PRESET=5: irq rises 8 edges after the enabling write.
        bus_write(2'd1, 32'd5);
        bus_write(2'd0, 32'h9);
        for (int i = 0; i <= 8; i++) begin
            probe($sformatf("os_ctrl_i%0d", i), 2'd0, 32'h9, (i == 8));
        end
        probe("os_en_cleared", 2'd0, 32'h8, 1'b1);
        probe("os_count_zero", 2'd2, 32'h0, 1'b1);
        probe("os_irq_held", 2'd1, 32'd5, 1'b1);
        bus_write(2'd0, 32'h8);
        probe("os_irq_cleared", 2'd0, 32'h8, 1'b0);

        // Auto-reload, PRESET=2: one-cycle pulse every 5 cycles, EN stays set.
        bus_write(2'd1, 32'd2);
        bus_write(2'd0, 32'hB);
        for (int i = 0; i <= 21; i++) begin
            probe($sformatf("ar_i%0d", i), 2'd0, 32'hB, (i > 0) && (i % 5 == 0));
        end
        bus_write(2'd0, 32'h0);
        tick();
        tick();

        // PRESET=100, disable mid-count: COUNT freezes, re-enable reloads.
        bus_write(2'd1, 32'd100);
        bus_write(2'd0, 32'h1);
        tick();
        tick();
        for (int i = 2; i <= 17; i++) begin
            probe($sformatf("pause_cnt_i%0d", i), 2'd2, 32'(102 - i), 1'b0);
        end
        bus_write(2'd0, 32'h0);
        probe("pause_frozen_a", 2'd2, 32'd83, 1'b0);
        probe("pause_frozen_b", 2'd2, 32'd83, 1'b0);
        probe("pause_frozen_c", 2'd2, 32'd83, 1'b0);
        probe("pause_ctrl", 2'd0, 32'h0, 1'b0);
        bus_write(2'd0, 32'h1);
        probe("restart_idle", 2'd2, 32'd83, 1'b0);
        probe("restart_load", 2'd2, 32'd83, 1'b0);
        probe("restart_reload", 2'd2, 32'd100, 1'b0);
        probe("restart_dec", 2'd2, 32'd99, 1'b0);
        bus_write(2'd0, 32'h0);
        tick();
        tick();

        // One-shot with IM=0: no irq; a CTRL write setting IM clears sticky.
        bus_write(2'd1, 32'd1);
        bus_write(2'd0, 32'h1);
        for (int i = 0; i <= 6; i++) begin
            probe($sformatf("masked_i%0d", i), 2'd0, (i < 5) ? 32'h1 : 32'h0, 1'b0);
        end
        bus_write(2'd0, 32'h8);
        probe("masked_unmask", 2'd0, 32'h8, 1'b0);
        probe("masked_unmask_b", 2'd0, 32'h8, 1'b0);

        // Async reset mid-count, then PRESET=0 reaches INT 3 edges after enable.
        bus_write(2'd1, 32'd50);
        bus_write(2'd0, 32'h9);
        tick();
        tick();
        for (int i = 2; i <= 21; i++) begin
            probe($sformatf("rst_cnt_i%0d", i), 2'd2, 32'(52 - i), 1'b0);
        end
        reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            probe($sformatf("async_rst_off%0d", a), 2'(a), 32'h0, 1'b0);
        end
        reset = 1'b1;
        tick();
        bus_write(2'd0, 32'h9);
        for (int i = 0; i <= 3; i++) begin
            probe($sformatf("p0_i%0d", i), 2'd0, 32'h9, (i == 3));
        end
        probe("p0_done", 2'd0, 32'h8, 1'b1);

        tick();
        n_total++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
